// File: rtl/sprite_update_queue.sv
// Sprite register-write queue: buffers CPU writes and replays them to the
// sprite engine only during vertical blanking, raising frame_irq after each drain.
module sprite_update_queue #(
  parameter  int DEPTH  = 8,
  parameter  int ADDR_W = 6,
  parameter  int DATA_W = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              vblank_start,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              busy,
  output logic              overflow,
  output logic              missed_vblank,
  output logic              frame_irq,
  input  logic              status_clear
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  drain_rem;
  logic              vblank_pend;
  logic              push, pop, vblank_eff;

  assign wr_ready   = (fifo_count != CNT_W'(DEPTH));
  assign push       = wr_valid && wr_ready;
  assign pop        = out_valid && out_ready;
  // A vblank seen during DONE is replayed on the following IDLE cycle.
  assign vblank_eff = vblank_start || vblank_pend;
  assign out_addr   = mem_addr[rd_ptr];
  assign out_data   = mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (vblank_eff) state_nxt = (fifo_count == '0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (pop && drain_rem == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == S_DRAIN);
    busy      = (state == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_rem   <= '0;
      vblank_pend <= 1'b0;
    end else begin
      vblank_pend <= (state == S_DONE) && vblank_start;
      if (state == S_IDLE && vblank_eff) drain_rem <= fifo_count;
      else if (state == S_DRAIN && pop)  drain_rem <= drain_rem - CNT_W'(1);
    end
  end

  // FIFO control; storage itself carries no reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= wr_addr;
      mem_data[wr_ptr] <= wr_data;
    end
  end

  // Sticky flags: a set event in the same cycle as status_clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow      <= 1'b0;
      missed_vblank <= 1'b0;
      frame_irq     <= 1'b0;
    end else begin
      overflow      <= (wr_valid && !wr_ready) || (overflow && !status_clear);
      missed_vblank <= ((state == S_DRAIN) && vblank_start) || (missed_vblank && !status_clear);
      frame_irq     <= (state == S_DONE) || (frame_irq && !status_clear);
    end
  end

endmodule

// File: tb/tb_sprite_update_queue.sv
// Randomized + directed bench for sprite_update_queue with a count-level
// reference model and an ordering scoreboard.
module tb_sprite_update_queue;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              vblank_start = 1'b0;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  fifo_count;
  logic              busy, overflow, missed_vblank, frame_irq;
  logic              status_clear = 1'b0;

  sprite_update_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .vblank_start(vblank_start), .out_valid(out_valid),
    .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready),
    .fifo_count(fifo_count), .busy(busy), .overflow(overflow),
    .missed_vblank(missed_vblank), .frame_irq(frame_irq), .status_clear(status_clear)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, entries released for the current blanking
  // drain, and sticky flags; the accepted writes form the expected order.
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int m_cnt = 0, m_left = 0;
  bit m_done = 0, m_pend = 0, m_ovf = 0, m_miss = 0, m_irq = 0;

  always @(posedge clk) begin
    bit m_pop, m_push, s_ovf, s_miss, s_irq, nd;
    if (!rst_n) begin
      m_cnt = 0; m_left = 0; m_done = 0; m_pend = 0;
      m_ovf = 0; m_miss = 0; m_irq = 0;
      exp_q.delete();
    end else begin
      m_pop  = (m_left > 0) && out_ready;
      m_push = wr_valid && (m_cnt < DEPTH);
      s_ovf  = wr_valid && (m_cnt == DEPTH);
      s_miss = vblank_start && (m_left > 0);
      s_irq  = m_done;
      nd     = 0;
      if (m_left > 0) begin
        if (m_pop) begin
          m_left--;
          if (m_left == 0) nd = 1;
        end
      end else if (m_done) begin
        m_pend = vblank_start;
      end else if (vblank_start || m_pend) begin
        m_left = m_cnt;
        m_pend = 0;
        if (m_cnt == 0) nd = 1;
      end
      m_done = nd;
      m_cnt  = m_cnt + int'(m_push) - int'(m_pop);
      if (m_push) exp_q.push_back({wr_addr, wr_data});
      m_ovf  = s_ovf  || (m_ovf  && !status_clear);
      m_miss = s_miss || (m_miss && !status_clear);
      m_irq  = s_irq  || (m_irq  && !status_clear);
    end
  end

  // Monitor on the falling edge: state checks plus scoreboard pop per handshake.
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    if (mon_en) begin
      chk("out_valid", out_valid, m_left > 0);
      chk("busy", busy, m_left > 0);
      chk("fifo_count", fifo_count, m_cnt);
      chk("wr_ready", wr_ready, m_cnt < DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("missed_vblank", missed_vblank, m_miss);
      chk("frame_irq", frame_irq, m_irq);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("entry", {out_addr, out_data}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic vblank();
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
  endtask

  task automatic clear();
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // Basic three-entry drain
    wr(6'h04, 16'h1020); wr(6'h06, 16'hA5A5); wr(6'h08, 16'h5A5A);
    chk("tp1_count", fifo_count, 3);
    chk("tp1_idle", out_valid, 0);
    repeat (2) tick();
    out_ready = 1'b1;
    vblank();
    repeat (3) tick();
    chk("tp1_irq_early", frame_irq, 0);
    tick();
    chk("tp1_irq", frame_irq, 1);
    chk("tp1_empty", fifo_count, 0);
    clear();

    // Overflow on a full FIFO
    for (int i = 0; i < DEPTH; i++) wr(6'(i + 1), 16'(16'h1111 * (i + 1)));
    chk("tp2_full", wr_ready, 0);
    wr(6'h0E, 16'hFFFF);
    chk("tp2_ovf", overflow, 1);
    chk("tp2_count", fifo_count, DEPTH);
    vblank();
    repeat (DEPTH + 2) tick();
    clear();

    // Stalled drain
    wr(6'h21, 16'hBEEF); wr(6'h22, 16'hCAFE);
    vblank();
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick(); tick();
    chk("tp3_busy_stall", busy, 1);
    out_ready = 1'b1; tick();
    chk("tp3_done", busy, 0);
    repeat (2) tick();

    // Push and vblank during DRAIN
    out_ready = 1'b0;
    wr(6'h30, 16'h0A0A); wr(6'h31, 16'h0B0B);
    vblank();
    wr_valid = 1'b1; wr_addr = 6'h10; wr_data = 16'h0001; vblank_start = 1'b1;
    tick();
    wr_valid = 1'b0; vblank_start = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("tp4_miss", missed_vblank, 1);
    chk("tp4_count", fifo_count, 1);
    vblank();
    repeat (4) tick();
    chk("tp4_drained", fifo_count, 0);
    clear();

    // Empty vblank, clear coinciding with DONE
    vblank();
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    chk("tp5_irq_set_wins", frame_irq, 1);
    tick();

    // Reset mid-drain
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(6'(6'h38 + i), 16'($urandom));
    vblank();
    out_ready = 1'b1; tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("tp6_valid", out_valid, 0);
    chk("tp6_count", fifo_count, 0);
    chk("tp6_ready", wr_ready, 1);
    chk("tp6_flags", {overflow, missed_vblank, frame_irq}, 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      wr_valid     = ($urandom_range(0, 99) < 45);
      wr_addr      = 6'($urandom);
      wr_data      = 16'($urandom);
      vblank_start = ($urandom_range(0, 99) < 6);
      out_ready    = ($urandom_range(0, 99) < 70);
      status_clear = ($urandom_range(0, 99) < 3);
      rst_n        = ($urandom_range(0, 499) != 0);
      tick();
    end
    wr_valid = 1'b0; vblank_start = 1'b0; status_clear = 1'b0; rst_n = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_update_queue.md
Name: sprite_update_queue

Overview:
Upstream stage of the sprite engine. Buffers CPU sprite-register writes (coords, bitmap words, control) in a FIFO and replays them into the sprite engine's register-write port only during vertical blanking, so sprites never tear mid-frame. It raises a frame interrupt once each blanking-period drain completes. It sits between the TinyQV peripheral bus decode and the sprite engine register file.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..16
ADDR_W, 6, register address width
DATA_W, 16, register data width

Ports:
clk  input  1  project clock
rst_n  input  1  reset, synchronous, active-low
wr_valid  input  1  CPU write request
wr_addr  input  ADDR_W  target sprite register address
wr_data  input  DATA_W  write data
wr_ready  output  1  high when FIFO not full
vblank_start  input  1  one-cycle pulse at the first non-active line of a frame
out_valid  output  1  replayed write valid toward the sprite engine
out_addr  output  ADDR_W  replayed address
out_data  output  DATA_W  replayed data
out_ready  input  1  sprite engine accepts the write
fifo_count  output  $clog2(DEPTH)+1  current occupancy
busy  output  1  high while in DRAIN
overflow  output  1  sticky: a write was dropped on a full FIFO
missed_vblank  output  1  sticky: vblank_start arrived while in DRAIN
frame_irq  output  1  sticky interrupt, set at end of each drain
status_clear  input  1  clears frame_irq, overflow, missed_vblank

Behaviour:
- One clock domain, clk. Reset is synchronous and active-low on rst_n: sampled only at posedge clk.
- Reset values: all outputs 0 except wr_ready=1; FIFO empty, pointers 0, state IDLE.
- FIFO: circular buffer, read/write pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0, plus occupancy counter.
- Push: when wr_valid && wr_ready. Entry visible to fifo_count next cycle.
- wr_valid while full (wr_ready=0): write dropped, FIFO unchanged, overflow set next cycle.
- Pop: when out_valid && out_ready. out_valid/out_addr/out_data come from the FIFO head combinationally; out_addr/out_data are don't-care when out_valid=0.
- Simultaneous push and pop: count unchanged, both pointers advance. A push while full is dropped even if a pop happens in the same cycle.
- States:
  - IDLE: out_valid=0. On vblank_start: latch drain_remaining = fifo_count. If nonzero, go to DRAIN; if zero, go directly to DONE.
  - DRAIN: busy=1; out_valid=1. Each pop decrements drain_remaining. Entries pushed during DRAIN are queued but not drained until the next vblank. When the pop that takes drain_remaining 1 -> 0 completes, go to DONE. out_ready low stalls indefinitely with head held stable.
  - DONE: single cycle. Set frame_irq, go to IDLE.
- vblank_start in DRAIN: ignored for draining; missed_vblank set. vblank_start in DONE is treated as if seen in IDLE on the following cycle: it is captured, not lost.
- status_clear: clears the three sticky flags next cycle. If a set event occurs in the same cycle, set wins.
- Reset mid-DRAIN: FIFO contents discarded, state IDLE, out_valid=0 in the cycle after the reset edge.
- No width promotion: addresses and data pass through unmodified. Entry ordering is strictly FIFO.

Test Plan:
- Reset, push (0x04,0x1020),(0x06,0xA5A5),(0x08,0x5A5A) -> fifo_count=3, out_valid=0 until vblank_start. Then out_valid for 3 consecutive cycles with out_ready=1, in that order. frame_irq=1 two cycles after the last pop. fifo_count=0.
- Fill 8 entries, 9th write (0x0E,0xFFFF) -> wr_ready=0, entry dropped, overflow=1, drained sequence contains exactly the first 8 entries.
- vblank_start with 2 entries, out_ready toggling 1,0,0,1 -> both entries delivered unchanged and in order, head held during stall, busy high for 4 cycles.
- During DRAIN of 2 entries push (0x10,0x0001) and pulse vblank_start -> only the original 2 are drained, missed_vblank=1, fifo_count=1 afterwards. The next vblank drains 0x10/0x0001.
- vblank_start on empty FIFO -> no out_valid, frame_irq=1 two cycles later. status_clear together with a new DONE -> frame_irq stays 1.
- Assert rst_n=0 for one cycle mid-DRAIN with 5 entries -> next cycle out_valid=0, fifo_count=0, all sticky flags 0, wr_ready=1.
